// File: rtl/ro_pkg.sv
// Shared types and defaults for the ring-oscillator measurement block.
// FSM state encoding, default parameters and index-width helper.
package ro_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_HOLD
  } ro_state_e;

  localparam int N_RO_DEF   = 4;
  localparam int CNT_W_DEF  = 16;
  localparam int WIN_W_DEF  = 16;
  localparam int SETTLE_DEF = 8;

  // Width of an index over n items; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronized rising-edge counter for one muxed oscillator channel.
// Saturation and overflow flag are enabled by RO_OVF_SAT_EN.
module ro_edge_counter
  import ro_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ro,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt_nxt,
  output logic             o_ovf_nxt
);

  // [0],[1] synchronizer, [2] previous value for edge detect
  logic [2:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             w_edge;
  logic             w_inc;

  assign w_edge = r_sync[1] & ~r_sync[2];
  assign w_inc  = i_en & w_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[1:0], i_ro};
    end
  end

`ifdef RO_OVF_SAT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic r_ovf;

  always_comb begin
    o_cnt_nxt = r_cnt;
    o_ovf_nxt = r_ovf;
    if (i_clr) begin
      o_cnt_nxt = '0;
      o_ovf_nxt = 1'b0;
    end else if (w_inc) begin
      if (r_cnt == CNT_MAX) begin
        o_ovf_nxt = 1'b1;
      end else begin
        o_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= o_cnt_nxt;
      r_ovf <= o_ovf_nxt;
    end
  end
`else
  always_comb begin
    o_cnt_nxt = r_cnt;
    if (i_clr) begin
      o_cnt_nxt = '0;
    end else if (w_inc) begin
      o_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  assign o_ovf_nxt = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= o_cnt_nxt;
    end
  end
`endif

endmodule

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement sequencer: settle, count window, hold result.
// Overflow saturation is available when RO_OVF_SAT_EN is defined.
module ro_meas_ctrl
  import ro_pkg::*;
#(
  parameter  int N_RO       = N_RO_DEF,
  parameter  int CNT_W      = CNT_W_DEF,
  parameter  int WIN_W      = WIN_W_DEF,
  parameter  int SETTLE_CYC = SETTLE_DEF,
  localparam int IW         = idx_w(N_RO)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             scan_all,
  input  logic [IW-1:0]    sel,
  input  logic [WIN_W-1:0] window,
  input  logic [N_RO-1:0]  ro_in,
  output logic [N_RO-1:0]  ro_en,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic [IW-1:0]    result_idx,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overflow
);

  localparam int SW = idx_w(SETTLE_CYC);

  ro_state_e        r_state;
  ro_state_e        w_nxt;
  logic             r_scan;
  logic [IW-1:0]    r_idx;
  logic [WIN_W-1:0] r_win;
  logic [SW-1:0]    r_scnt;
  logic [WIN_W-1:0] r_wcnt;
  logic [CNT_W-1:0] r_result;
  logic [IW-1:0]    r_res_idx;
  logic             r_ovf;

  logic             w_acc;
  logic             w_set_done;
  logic             w_win_done;
  logic             w_last_idx;
  logic             w_step;
  logic             w_clr;
  logic             w_en;
  logic             w_ro;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;

  assign w_acc      = start && (r_state == S_IDLE);
  assign w_set_done = r_scnt == SW'(SETTLE_CYC - 1);
  assign w_win_done = r_wcnt == (r_win - WIN_W'(1));
  assign w_last_idx = r_idx == IW'(N_RO - 1);
  assign w_step     = (r_state == S_HOLD) && result_ready
                      && r_scan && !w_last_idx;
  assign w_ro       = ro_in[r_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_nxt = S_SETTLE;
      S_SETTLE: if (w_set_done) w_nxt = S_COUNT;
      S_COUNT:  if (w_win_done) w_nxt = S_HOLD;
      S_HOLD: begin
        if (result_ready) begin
          w_nxt = (r_scan && !w_last_idx) ? S_SETTLE : S_IDLE;
        end
      end
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ro_en        = '0;
    busy         = r_state != S_IDLE;
    result_valid = r_state == S_HOLD;
    w_clr        = r_state == S_SETTLE;
    w_en         = r_state == S_COUNT;
    if ((r_state == S_SETTLE) || (r_state == S_COUNT)) begin
      ro_en[r_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan    <= 1'b0;
      r_idx     <= '0;
      r_win     <= '0;
      r_scnt    <= '0;
      r_wcnt    <= '0;
      r_result  <= '0;
      r_res_idx <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_scnt <= (r_state == S_SETTLE) ? r_scnt + SW'(1) : '0;
      r_wcnt <= (r_state == S_COUNT) ? r_wcnt + WIN_W'(1) : '0;
      if (w_acc) begin
        r_scan <= scan_all;
        r_idx  <= scan_all ? '0 : sel;
        r_win  <= (window == '0) ? WIN_W'(1) : window;
      end
      if (w_step) begin
        r_idx <= r_idx + IW'(1);
      end
      // Capture the counter's next value so the final window cycle counts.
      if ((r_state == S_COUNT) && w_win_done) begin
        r_result  <= w_cnt_nxt;
        r_res_idx <= r_idx;
        r_ovf     <= w_ovf_nxt;
      end
    end
  end

  ro_edge_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_ro     (w_ro),
    .i_clr    (w_clr),
    .i_en     (w_en),
    .o_cnt_nxt(w_cnt_nxt),
    .o_ovf_nxt(w_ovf_nxt)
  );

  assign result     = r_result;
  assign result_idx = r_res_idx;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Self-checking bench for ro_meas_ctrl: vector table, corner sequences,
// randomized single measurements and a narrow-counter overflow instance.
module tb_ro_meas_ctrl;

  localparam int S = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        scan_all = 1'b0;
  logic [1:0]  sel = '0;
  logic [15:0] window = '0;
  logic [3:0]  ro_in = '0;
  logic [3:0]  ro_en;
  logic        busy;
  logic [15:0] result;
  logic [1:0]  result_idx;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic        overflow;

  logic        s_start = 1'b0;
  logic [3:0]  s_ro = '0;
  logic [3:0]  s_ro_en;
  logic        s_busy;
  logic [3:0]  s_result;
  logic [1:0]  s_result_idx;
  logic        s_valid;
  logic        s_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int per[4] = '{4, 4, 4, 4};

  typedef struct {
    int sel;
    int win;
    int per;
    int lo;
    int hi;
  } vec_t;

  vec_t vecs[7];

  ro_meas_ctrl u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .scan_all    (scan_all),
    .sel         (sel),
    .window      (window),
    .ro_in       (ro_in),
    .ro_en       (ro_en),
    .busy        (busy),
    .result      (result),
    .result_idx  (result_idx),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .overflow    (overflow)
  );

  ro_meas_ctrl #(
    .CNT_W(4)
  ) u_small (
    .clk         (clk),
    .rst         (rst),
    .start       (s_start),
    .scan_all    (1'b0),
    .sel         (2'd0),
    .window      (16'd100),
    .ro_in       (s_ro),
    .ro_en       (s_ro_en),
    .busy        (s_busy),
    .result      (s_result),
    .result_idx  (s_result_idx),
    .result_valid(s_valid),
    .result_ready(1'b1),
    .overflow    (s_ovf)
  );

  always #5 clk = ~clk;

  // Oscillator models: square waves of per[i] clk cycles, changing off-edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      ro_in[i] = (cyc % per[i]) < (per[i] / 2);
    end
    s_ro = {4{(cyc % 4) < 2}};
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic kick(input bit sc, input int s, input int w);
    @(negedge clk);
    scan_all = sc;
    sel      = 2'(s);
    window   = 16'(w);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Called on a negedge in the first SETTLE cycle of a measurement.
  task automatic wait_res(input string nm, input int idx, input int lat,
                          input int lo, input int hi);
    int k = 0;
    int enbad = 0;
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    while (!result_valid && k < 5000) begin
      if (ro_en !== oh) enbad++;
      @(negedge clk);
      k++;
    end
    chk({nm, "_lat"}, k, lat);
    chk({nm, "_roen"}, enbad, 0);
    chk({nm, "_roen_hold"}, int'(ro_en), 0);
    chk({nm, "_idx"}, int'(result_idx), idx);
    chk_rng({nm, "_cnt"}, int'(result), lo, hi);
  endtask

  initial begin
    int r_keep;
    int i_keep;
    int unstable;
    int k;

    vecs[0] = '{2, 60, 6, 9, 11};
    vecs[1] = '{0, 100, 4, 24, 26};
    vecs[2] = '{1, 100, 10, 9, 11};
    vecs[3] = '{3, 100, 20, 4, 6};
    vecs[4] = '{3, 0, 4, 0, 1};
    vecs[5] = '{1, 1, 4, 0, 1};
    vecs[6] = '{0, 200, 50, 3, 5};

    repeat (3) @(negedge clk);
    chk("rst_roen", int'(ro_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_idx", int'(result_idx), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst = 1'b0;

    // Vector table: single-mode measurements with ready held high
    for (int i = 0; i < 7; i++) begin
      per[vecs[i].sel] = vecs[i].per;
      result_ready = 1'b1;
      kick(1'b0, vecs[i].sel, vecs[i].win);
      wait_res($sformatf("vec%0d", i), vecs[i].sel,
               S + ((vecs[i].win == 0) ? 1 : vecs[i].win),
               vecs[i].lo, vecs[i].hi);
      chk($sformatf("vec%0d_ovf", i), int'(overflow), 0);
      @(negedge clk);
      chk($sformatf("vec%0d_busy_after", i), int'(busy), 0);
    end

    // Scan mode over all four oscillators
    per = '{4, 10, 20, 50};
    kick(1'b1, 0, 100);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: wait_res("scan0", 0, S + 100, 24, 26);
        1: wait_res("scan1", 1, S + 100, 9, 11);
        2: wait_res("scan2", 2, S + 100, 4, 6);
        default: wait_res("scan3", 3, S + 100, 1, 3);
      endcase
      @(negedge clk);
    end
    chk("scan_busy_after", int'(busy), 0);

    // Backpressure: result held stable while ready is low
    result_ready = 1'b0;
    kick(1'b1, 0, 40);
    wait_res("bp0", 0, S + 40, 9, 11);
    r_keep = int'(result);
    i_keep = int'(result_idx);
    unstable = 0;
    repeat (20) begin
      @(negedge clk);
      if (int'(result) != r_keep || int'(result_idx) != i_keep
          || result_valid !== 1'b1 || ro_en !== 4'b0000) unstable++;
    end
    chk("bp_stable", unstable, 0);
    result_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_roen", int'(ro_en), 2);
    chk("bp_next_valid", int'(result_valid), 0);
    chk("bp_next_busy", int'(busy), 1);
    wait_res("bp1", 1, S + 40, 3, 5);
    @(negedge clk);
    wait_res("bp2", 2, S + 40, 1, 3);
    @(negedge clk);
    wait_res("bp3", 3, S + 40, 0, 1);
    @(negedge clk);
    chk("bp_busy_after", int'(busy), 0);

    // Start while busy is ignored
    per[1] = 10;
    kick(1'b0, 1, 50);
    repeat (2) @(negedge clk);
    scan_all = 1'b1;
    sel      = 2'd3;
    window   = 16'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_res("ignst", 1, S + 50 - 3, 4, 6);
    @(negedge clk);
    chk("ignst_busy_after", int'(busy), 0);

    // Randomized single measurements against an edges-per-window model
    for (int t = 0; t < 12; t++) begin
      int s;
      int p;
      int w;
      s = int'($urandom_range(0, 3));
      p = 2 * int'($urandom_range(2, 20));
      w = int'($urandom_range(1, 150));
      per[s] = p;
      kick(1'b0, s, w);
      wait_res($sformatf("rnd%0d", t), s, S + w,
               (w / p) - 1, ((w + p - 1) / p) + 1);
      @(negedge clk);
      chk($sformatf("rnd%0d_busy_after", t), int'(busy), 0);
    end

    // Reset pulse during COUNT aborts everything
    per[2] = 6;
    kick(1'b0, 2, 100);
    repeat (S + 5) @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_roen", int'(ro_en), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_idx", int'(result_idx), 0);
    chk("mid_rst_valid", int'(result_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_valid", int'(result_valid), 0);
    chk("post_rst_roen", int'(ro_en), 0);

    // Narrow counter: 25 edges in a 4-bit counter
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    k = 0;
    while (!s_valid && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("small_lat", k, S + 100);
`ifdef RO_OVF_SAT_EN
    chk("small_sat_result", int'(s_result), 15);
    chk("small_sat_ovf", int'(s_ovf), 1);
`else
    chk_rng("small_wrap_result", int'(s_result), 8, 10);
    chk("small_wrap_ovf", int'(s_ovf), 0);
`endif
    @(negedge clk);
    chk("small_busy_after", int'(s_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
